// File: rtl/muller_c_sync.sv
// Clocked array of WIDTH independent NIN-input Muller C-elements with input synchronisers,
// optional asymmetric (plus-input) release, transition strobes and a saturating counter.
module muller_c_sync #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned NIN         = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        INIT        = 1'b0,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH*NIN-1:0]   in_data,
    input  logic                   asym,
    input  logic [NIN-1:0]         plus_mask,
    input  logic                   en,
    input  logic                   clr_cnt,
    output logic [WIDTH-1:0]       c_out,
    output logic [WIDTH-1:0]       c_rise,
    output logic [WIDTH-1:0]       c_fall,
    output logic                   all_high,
    output logic                   all_low,
    output logic [CNT_W-1:0]       trans_cnt
);

    localparam int unsigned N  = WIDTH * NIN;
    localparam int unsigned PW = $clog2(WIDTH + 1);
    localparam int unsigned SW = ((CNT_W > PW) ? CNT_W : PW) + 1;

    logic [N-1:0] s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = in_data;
        end else begin : g_sync
            logic [N-1:0] sync_q [SYNC_STAGES];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= {N{INIT}};
                    end
                end else begin
                    sync_q[0] <= in_data;
                    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    logic [WIDTH-1:0] c_q, c_d, rise_q, rise_d, fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NIN-1:0]   fall_mask;
    logic [PW-1:0]    pop;
    logic [SW-1:0]    sum, cnt_max;

    // An all-ones plus_mask would leave no bit to release on, so fall back to symmetric.
    assign fall_mask = (asym && (plus_mask != {NIN{1'b1}})) ? ~plus_mask : {NIN{1'b1}};

    always_comb begin
        c_d = c_q;
        if (en) begin
            for (int unsigned k = 0; k < WIDTH; k++) begin
                if (&s[k*NIN +: NIN]) begin
                    c_d[k] = 1'b1;
                end else if ((s[k*NIN +: NIN] & fall_mask) == '0) begin
                    c_d[k] = 1'b0;
                end
            end
        end
        rise_d = c_d & ~c_q;
        fall_d = ~c_d & c_q;
    end

    always_comb begin
        pop = '0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            pop = pop + PW'(rise_d[k] | fall_d[k]);
        end
        sum     = SW'(cnt_q) + SW'(pop);
        cnt_max = SW'({CNT_W{1'b1}});
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (sum > cnt_max) begin
            cnt_d = cnt_max[CNT_W-1:0];
        end else begin
            cnt_d = sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q    <= {WIDTH{INIT}};
            rise_q <= '0;
            fall_q <= '0;
            cnt_q  <= '0;
        end else begin
            c_q    <= c_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            cnt_q  <= cnt_d;
        end
    end

    assign c_out     = c_q;
    assign c_rise    = rise_q;
    assign c_fall    = fall_q;
    assign trans_cnt = cnt_q;
    assign all_high  = &c_q;
    assign all_low   = ~|c_q;

endmodule

// File: tb/tb_muller_c_sync.sv
// Bench for muller_c_sync: directed literal checks plus randomized traffic compared every
// cycle against a queue-based behavioural model.
module tb_muller_c_sync;

    localparam int   W   = 4;
    localparam int   NI  = 3;
    localparam int   SS  = 2;
    localparam int   CW  = 4;
    localparam logic INI = 1'b0;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [W*NI-1:0] in_data = '0;
    logic            asym = 1'b0;
    logic [NI-1:0]   plus_mask = '0;
    logic            en = 1'b1;
    logic            clr_cnt = 1'b0;
    logic [W-1:0]    c_out, c_rise, c_fall;
    logic            all_high, all_low;
    logic [CW-1:0]   trans_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    muller_c_sync #(
        .WIDTH(W), .NIN(NI), .SYNC_STAGES(SS), .INIT(INI), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .asym(asym), .plus_mask(plus_mask),
        .en(en), .clr_cnt(clr_cnt), .c_out(c_out), .c_rise(c_rise), .c_fall(c_fall),
        .all_high(all_high), .all_low(all_low), .trans_cnt(trans_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the sampled input history is a queue, newest first; the C-element sees the
    // value that entered SS edges ago.
    logic [W*NI-1:0] hist[$];
    logic [W-1:0]    m_c, m_r, m_f;
    int              m_cnt;

    always @(posedge clk or negedge rst_n) begin : model
        logic [W*NI-1:0] sv;
        int n_ones, n_plus_ones, n;
        bit asym_active;
        if (!rst_n) begin
            hist.delete();
            for (int i = 0; i < SS; i++) hist.push_back({W*NI{INI}});
            m_c   = {W{INI}};
            m_r   = '0;
            m_f   = '0;
            m_cnt = 0;
        end else begin
            sv = hist[SS-1];
            void'(hist.pop_back());
            hist.push_front(in_data);
            m_r = '0;
            m_f = '0;
            asym_active = asym && ($countones(plus_mask) != NI);
            if (en) begin
                for (int k = 0; k < W; k++) begin
                    n_ones = 0;
                    n_plus_ones = 0;
                    for (int b = 0; b < NI; b++) begin
                        if (sv[k*NI+b]) begin
                            n_ones++;
                            if (plus_mask[b]) n_plus_ones++;
                        end
                    end
                    if (n_ones == NI) begin
                        if (!m_c[k]) m_r[k] = 1'b1;
                    end else if (n_ones - (asym_active ? n_plus_ones : 0) == 0) begin
                        if (m_c[k]) m_f[k] = 1'b1;
                    end
                end
            end
            m_c = (m_c | m_r) & ~m_f;
            n = $countones(m_r | m_f);
            if (clr_cnt) m_cnt = 0;
            else if (m_cnt + n > 2**CW - 1) m_cnt = 2**CW - 1;
            else m_cnt = m_cnt + n;
        end
    end

    always @(negedge clk) begin
        chk("model c_out", 32'(c_out), 32'(m_c));
        chk("model c_rise", 32'(c_rise), 32'(m_r));
        chk("model c_fall", 32'(c_fall), 32'(m_f));
        chk("model all_high", 32'(all_high), 32'(m_c == {W{1'b1}}));
        chk("model all_low", 32'(all_low), 32'(m_c == '0));
        chk("model trans_cnt", 32'(trans_cnt), 32'(m_cnt));
    end

    task automatic drive(input logic [W*NI-1:0] d);
        @(negedge clk);
        #1;
        in_data = d;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        edges(1);
        chk("reset c_out", 32'(c_out), 32'h0);
        chk("reset all_low", 32'(all_low), 32'h1);
        chk("reset all_high", 32'(all_high), 32'h0);
        chk("reset trans_cnt", 32'(trans_cnt), 32'h0);

        drive(12'h003); edges(4);
        chk("partial no rise", 32'(c_out), 32'h0);
        drive(12'h007); edges(2);
        chk("rise latency early", 32'(c_out), 32'h0);
        edges(1);
        chk("rise c_out", 32'(c_out), 32'h1);
        chk("rise strobe", 32'(c_rise), 32'h1);
        chk("rise cnt", 32'(trans_cnt), 32'h1);
        edges(1);
        chk("strobe one cycle", 32'(c_rise), 32'h0);

        drive(12'h006); edges(4);
        chk("sym hold c_out", 32'(c_out), 32'h1);
        chk("sym hold cnt", 32'(trans_cnt), 32'h1);
        drive(12'h000); edges(3);
        chk("fall strobe", 32'(c_fall), 32'h1);
        chk("fall c_out", 32'(c_out), 32'h0);
        chk("fall cnt", 32'(trans_cnt), 32'h2);

        @(negedge clk); #1; asym = 1'b1; plus_mask = 3'b100;
        drive(12'h038); edges(3);
        chk("asym rise ch1", 32'(c_out), 32'h2);
        drive(12'h020); edges(3);
        chk("asym fall strobe", 32'(c_fall), 32'h2);
        chk("asym fall c_out", 32'(c_out), 32'h0);
        chk("asym fall cnt", 32'(trans_cnt), 32'h4);
        drive(12'h018); edges(4);
        chk("asym no rise", 32'(c_out), 32'h0);
        drive(12'h038); edges(3);
        chk("asym rise strobe", 32'(c_rise), 32'h2);
        chk("asym rise cnt", 32'(trans_cnt), 32'h5);
        @(negedge clk); #1; plus_mask = 3'b111;
        drive(12'h020); edges(4);
        chk("all-plus is symmetric", 32'(c_out), 32'h2);
        @(negedge clk); #1; asym = 1'b0; plus_mask = 3'b000;

        drive(12'h000); edges(3);
        chk("ch1 release cnt", 32'(trans_cnt), 32'h6);
        @(negedge clk); #1; clr_cnt = 1'b1;
        edges(1);
        chk("clr cnt", 32'(trans_cnt), 32'h0);
        @(negedge clk); #1; clr_cnt = 1'b0;
        drive(12'hFFF); edges(3);
        chk("completion all_high", 32'(all_high), 32'h1);
        chk("completion strobes", 32'(c_rise), 32'hF);
        chk("completion cnt", 32'(trans_cnt), 32'h4);
        @(negedge clk); #1; en = 1'b0; in_data = '0;
        edges(5);
        chk("en=0 hold", 32'(c_out), 32'hF);
        chk("en=0 cnt", 32'(trans_cnt), 32'h4);
        @(negedge clk); #1; en = 1'b1;
        edges(1);
        chk("en release falls", 32'(c_fall), 32'hF);
        chk("en release all_low", 32'(all_low), 32'h1);
        chk("en release cnt", 32'(trans_cnt), 32'h8);

        drive(12'hFFF); edges(3);
        chk("cnt 12", 32'(trans_cnt), 32'hC);
        drive(12'h000); edges(3);
        chk("cnt saturates", 32'(trans_cnt), 32'hF);
        drive(12'hFFF); edges(3);
        chk("cnt stays saturated", 32'(trans_cnt), 32'hF);
        drive(12'h000); edges(2);
        @(negedge clk); #1; clr_cnt = 1'b1;
        edges(1);
        chk("clr with transition strobe", 32'(c_fall), 32'hF);
        chk("clr discards transitions", 32'(trans_cnt), 32'h0);
        @(negedge clk); #1; clr_cnt = 1'b0;

        drive(12'hFFF); edges(3);
        chk("pre-reset cnt", 32'(trans_cnt), 32'h4);
        drive(12'h000); edges(2);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset c_out", 32'(c_out), 32'h0);
        chk("async reset cnt", 32'(trans_cnt), 32'h0);
        chk("async reset strobes", 32'(c_rise | c_fall), 32'h0);
        @(negedge clk); #1; rst_n = 1'b1;
        edges(4);
        chk("post-reset no strobe", 32'(c_rise | c_fall), 32'h0);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            #1;
            for (int k = 0; k < W; k++) begin
                case ($urandom_range(0, 3))
                    0:       in_data[k*NI +: NI] = '1;
                    1:       in_data[k*NI +: NI] = '0;
                    default: in_data[k*NI +: NI] = NI'($urandom);
                endcase
            end
            if ($urandom_range(0, 49) == 0) asym = ~asym;
            if ($urandom_range(0, 49) == 0) plus_mask = NI'($urandom);
            en = ($urandom_range(0, 9) != 0);
            clr_cnt = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 399) == 0) begin
                #2 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/muller_c_sync.md
# muller_c_sync

Clocked, parametrised array of Muller C-elements for the FPGA handshake fabric. It replaces the single-latch, two-input, gate-derived C-gate with WIDTH independent NIN-input channels, evaluated on one clock. The block adds input synchronisers, an asymmetric (plus-input) mode, per-channel transition strobes, completion flags and a saturating transition counter. It sits between asynchronous request/acknowledge wires and the synchronous control logic that consumes completion events.

## Interface
- WIDTH, 4: number of independent C-element channels (1..32).
- NIN, 2: inputs per channel (2..8).
- SYNC_STAGES, 2: synchroniser flops per input bit (0 = inputs used directly; legal 0..4).
- INIT, 1'b0: reset value of every c_out bit and every synchroniser flop.
- CNT_W, 8: width of the transition counter.

- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  WIDTH*NIN  channel k inputs are in_data[k*NIN +: NIN].
- asym  in  1  0 = symmetric C-element; 1 = asymmetric using plus_mask.
- plus_mask  in  NIN  1 marks a plus input; applies to every channel; static while asym=1.
- en  in  1  1 = evaluate; 0 = freeze outputs, strobes and counter.
- clr_cnt  in  1  synchronous clear of trans_cnt.
- c_out  out  WIDTH  registered C-element state per channel.
- c_rise  out  WIDTH  one-cycle strobe: channel went 0->1 this cycle.
- c_fall  out  WIDTH  one-cycle strobe: channel went 1->0 this cycle.
- all_high  out  1  every c_out bit is 1.
- all_low  out  1  every c_out bit is 0.
- trans_cnt  out  CNT_W  saturating count of channel transitions.

## Operation
- Synchroniser: each in_data bit passes through SYNC_STAGES flops. s[k] is the synchronised NIN-bit vector of channel k. The synchronisers run regardless of en.
- Rise condition per channel: all bits of s[k] are 1.
- Fall condition, symmetric (asym=0): all bits of s[k] are 0.
- Fall condition, asymmetric (asym=1): all non-plus bits of s[k] are 0; plus bits are ignored. If plus_mask is all ones, the symmetric fall condition is used.
- Next state when en=1:
  - rise condition true -> 1.
  - fall condition true -> 0.
  - otherwise hold.
  - Rise and fall cannot both be true for a given input vector, except in the asymmetric case where all non-plus bits are 0 and all plus bits are 1. This cannot happen, because rise requires every bit 1. No priority rule is therefore required, but the implementation must prioritise rise.
- en=0: c_out holds; c_rise and c_fall are 0; trans_cnt holds; clr_cnt is still honoured.
- c_rise[k] and c_fall[k] are registered alongside c_out and are high exactly in the cycle in which the new c_out value is first visible.
- all_high and all_low are combinational from the c_out register. For WIDTH=1 they equal c_out and ~c_out.
- trans_cnt:
  - Each cycle, adds popcount(c_rise | c_fall) as computed for the next state.
  - Saturates at 2^CNT_W-1 and never wraps.
  - clr_cnt=1 forces 0; transitions in that same cycle are discarded.
- Reset (rst_n=0, asynchronous): all synchroniser flops and c_out = INIT; c_rise = c_fall = 0; trans_cnt = 0; all_high = INIT; all_low = ~INIT. No strobe may fire on the first edge after reset unless the synchronised inputs actually meet a condition.
- Reset asserted mid-transition: state returns to the reset values immediately, and no partial strobe is emitted.

## Timing
- Latency from an in_data change to a c_out change is SYNC_STAGES+1 rising edges. With SYNC_STAGES=0, c_out updates on the first edge after the inputs settle.
- Strobe width is exactly one cycle per transition. A channel toggles at most once per cycle.
- An input glitch shorter than one clock period may be missed. Only sampled values matter.
- A plus_mask change while asym=1 takes effect on the next evaluation edge. It is unsynchronised and must be quasi-static.
- trans_cnt reflects a cycle's transitions one edge later, in the same cycle as the strobes.

## Test plan
- WIDTH=4, NIN=2, SYNC_STAGES=2, INIT=0. Drive channel 0 inputs 2'b01 -> c_out[0] stays 0. Then drive 2'b11 -> c_out[0]=1 and c_rise[0]=1 exactly 3 edges later; trans_cnt=1.
- Symmetric hold: from c_out[0]=1, drive 2'b10 -> c_out[0] stays 1 with no strobe. Drive 2'b00 -> c_fall[0] pulses, c_out[0]=0, trans_cnt=2.
- Asymmetric: asym=1, NIN=3, plus_mask=3'b100, c_out[1]=1. Drive channel 1 inputs 3'b100 -> c_out[1] falls. Drive 3'b011 -> no rise. Drive 3'b111 -> rise.
- Completion: drive all channels to all-ones -> all_high=1 after 3 edges and trans_cnt=4. Hold en=0 while driving all-zeros -> c_out unchanged. Raise en -> four c_fall strobes on the same edge, all_low=1, trans_cnt=8.
- Saturation and clear: CNT_W=3. Produce 9 transitions -> trans_cnt=7. Assert clr_cnt in the same cycle as a transition -> trans_cnt=0.
- Reset: INIT=1, toggle inputs, then assert rst_n=0 mid-sequence -> c_out=4'hF, strobes 0, trans_cnt=0 asynchronously. Release with inputs all 1 -> no strobes.
